// File: rtl/rom_ctrl_check_seq.sv
// ---------------------------------------------------------------------------
// rom_ctrl_check_seq
//
// Boot-time ROM integrity sequencer. After reset it owns the ROM read port,
// streams the image body (all words below the top DigestWords) into the KMAC
// hash input, then reads the expected digest from the top DigestWords words.
// It compares that expected digest with the digest KMAC returns. The outcome
// goes to pwrmgr and the computed digest goes to keymgr. When the check
// completes, the ROM is released to the bus.
//
// Build option:
//   ROM_CTRL_CHECK_BYPASS_EN - when defined, the checker is not built. From
//   the first cycle after reset the block reports done/good, presents a zero
//   digest marked valid, and hands the ROM to the bus.
//
// Parameters:
//   RomDepth    ROM size in 32-bit words (must exceed DigestWords)
//   AddrW       ROM word address width, $clog2(RomDepth)
//   DigestWords expected-digest words at the top of ROM (at most 8)
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   rom_req_o/addr_o     ROM read strobe/address; data returns 1 cycle later
//   rom_rdata_i          ROM read data
//   kmac_data_*          hash input stream (valid/data/last, ready)
//   kmac_digest_*        single-cycle computed-digest pulse and value
//   bus_sel_o            1: checker owns ROM, 0: bus owns ROM
//   pwrmgr_data_o        {done, good}
//   keymgr_data_o        {digest[255:0], valid}
//   alert_o              fatal alert, sticky until reset
// ---------------------------------------------------------------------------
module rom_ctrl_check_seq #(
  parameter int RomDepth    = 64,
  parameter int AddrW       = 6,
  parameter int DigestWords = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             rom_req_o,
  output logic [AddrW-1:0] rom_addr_o,
  input  logic [31:0]      rom_rdata_i,
  output logic             kmac_data_valid_o,
  output logic [31:0]      kmac_data_o,
  output logic             kmac_data_last_o,
  input  logic             kmac_data_ready_i,
  input  logic             kmac_digest_valid_i,
  input  logic [255:0]     kmac_digest_i,
  output logic             bus_sel_o,
  output logic [1:0]       pwrmgr_data_o,
  output logic [256:0]     keymgr_data_o,
  output logic             alert_o
);

`ifdef ROM_CTRL_CHECK_BYPASS_EN

  // Low during reset, high from the first edge after reset release.
  logic byp_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byp_q <= 1'b0;
    end else begin
      byp_q <= 1'b1;
    end
  end

  assign rom_req_o         = 1'b0;
  assign rom_addr_o        = '0;
  assign kmac_data_valid_o = 1'b0;
  assign kmac_data_o       = '0;
  assign kmac_data_last_o  = 1'b0;
  assign bus_sel_o         = ~byp_q;
  assign pwrmgr_data_o     = {byp_q, byp_q};
  assign keymgr_data_o     = {256'h0, byp_q};
  assign alert_o           = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{rom_rdata_i, kmac_data_ready_i, kmac_digest_valid_i, kmac_digest_i};

`else

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    REQ      = 4'd1,
    DATA     = 4'd2,
    PUSH     = 4'd3,
    TOP_REQ  = 4'd4,
    TOP_DATA = 4'd5,
    WAIT_DIG = 4'd6,
    CMP      = 4'd7,
    DONE     = 4'd8,
    ERROR    = 4'd9
  } state_e;

  localparam logic [AddrW-1:0] LastBody = AddrW'(RomDepth - DigestWords - 1);
  localparam logic [AddrW-1:0] TopBase  = AddrW'(RomDepth - DigestWords);
  localparam logic [AddrW-1:0] TopLast  = AddrW'(RomDepth - 1);

  state_e             state_q, state_d;
  logic [AddrW-1:0]   cnt_q, cnt_d;
  logic [31:0]        data_q;
  logic [255:0]       exp_q;
  logic [255:0]       dig_q;
  logic               dig_vld_q;
  logic [1:0]         pwr_q;
  logic [256:0]       key_q;
  logic               bus_sel_q;
  logic               alert_q;
  logic [2:0]         top_idx;
  logic               dig_match;
  logic               dig_window;

  // Word slot inside the expected digest for the current top-of-ROM read.
  assign top_idx   = 3'(cnt_q - TopBase);
  assign dig_match = (dig_q == exp_q);
  // A digest is only legitimate once the whole body has been pushed.
  assign dig_window = (state_q == TOP_REQ) || (state_q == TOP_DATA) || (state_q == WAIT_DIG);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        cnt_d   = '0;
      end
      REQ:  state_d = kmac_digest_valid_i ? ERROR : DATA;
      DATA: state_d = kmac_digest_valid_i ? ERROR : PUSH;
      PUSH: begin
        if (kmac_digest_valid_i) begin
          state_d = ERROR;
        end else if (kmac_data_ready_i) begin
          if (cnt_q == LastBody) begin
            cnt_d   = TopBase;
            state_d = TOP_REQ;
          end else begin
            cnt_d   = cnt_q + AddrW'(1);
            state_d = REQ;
          end
        end
      end
      TOP_REQ: state_d = TOP_DATA;
      TOP_DATA: begin
        if (cnt_q == TopLast) begin
          state_d = WAIT_DIG;
        end else begin
          cnt_d   = cnt_q + AddrW'(1);
          state_d = TOP_REQ;
        end
      end
      WAIT_DIG: begin
        if (dig_vld_q) begin
          state_d = CMP;
        end
      end
      CMP:     state_d = DONE;
      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q    <= '0;
      exp_q     <= '0;
      dig_q     <= '0;
      dig_vld_q <= 1'b0;
      pwr_q     <= 2'b00;
      key_q     <= '0;
      bus_sel_q <= 1'b1;
      alert_q   <= 1'b0;
    end else begin
      if (state_q == DATA) begin
        data_q <= rom_rdata_i;
      end
      if (state_q == TOP_DATA) begin
        exp_q[32*top_idx +: 32] <= rom_rdata_i;
      end
      if (kmac_digest_valid_i && dig_window) begin
        dig_vld_q <= 1'b1;
        dig_q     <= kmac_digest_i;
      end
      // Result outputs are written only on the way into a terminal state.
      if (state_d == ERROR) begin
        alert_q   <= 1'b1;
        pwr_q     <= 2'b10;
        key_q     <= '0;
        bus_sel_q <= 1'b1;
      end else if (state_q == CMP) begin
        pwr_q     <= {1'b1, dig_match};
        key_q     <= {dig_q, 1'b1};
        bus_sel_q <= 1'b0;
      end
    end
  end

  assign rom_req_o         = (state_q == REQ) || (state_q == TOP_REQ);
  assign rom_addr_o        = cnt_q;
  assign kmac_data_valid_o = (state_q == PUSH);
  assign kmac_data_o       = data_q;
  assign kmac_data_last_o  = (state_q == PUSH) && (cnt_q == LastBody);
  assign bus_sel_o         = bus_sel_q;
  assign pwrmgr_data_o     = pwr_q;
  assign keymgr_data_o     = key_q;
  assign alert_o           = alert_q;

`endif

endmodule
